// File: rtl/antirebote_multicanal.sv
// Multi-channel pin synchronizer and debouncer: per-channel sync chain, restart-on-bounce
// stability counter, debounced level, press/release pulses and a one-shot long-press pulse.

module antirebote_canal #(
  parameter int   SYNC_ETAPAS     = 2,
  parameter int   DEBOUNCE_CICLOS = 270000,
  parameter int   LARGA_CICLOS    = 27000000,
  parameter logic INVERTIR        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic habilitar_i,
  input  logic entrada_i,
  output logic estable_o,
  output logic subida_o,
  output logic bajada_o,
  output logic larga_o
);
  localparam int CW = $clog2(DEBOUNCE_CICLOS);
  localparam int LW = $clog2(LARGA_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [LW-1:0] LARGA_MAX = LW'(LARGA_CICLOS);
  localparam logic [LW-1:0] LARGA_PRE = LW'(LARGA_CICLOS - 1);

  logic [SYNC_ETAPAS-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [LW-1:0]          cntl_q, cntl_d;
  logic                   est_q, est_d;
  logic                   sub_q, sub_d, baj_q, baj_d, larga_q, larga_d;
  logic                   sinc;

  assign sinc = sync_q[SYNC_ETAPAS-1];

  always_comb begin
    cnt_d   = cnt_q;
    cntl_d  = cntl_q;
    est_d   = est_q;
    sub_d   = 1'b0;
    baj_d   = 1'b0;
    larga_d = 1'b0;
    if (!habilitar_i) begin
      cnt_d  = '0;
      cntl_d = '0;
    end else begin
      // any sample agreeing with the accepted level restarts the stability window
      if (sinc == est_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        est_d = sinc;
        sub_d = sinc;
        baj_d = !sinc;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // saturating hold counter makes the long-press pulse fire once per press
      if (!est_q) begin
        cntl_d = '0;
      end else if (cntl_q != LARGA_MAX) begin
        cntl_d  = cntl_q + 1'b1;
        larga_d = (cntl_q == LARGA_PRE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      cntl_q  <= '0;
      est_q   <= 1'b0;
      sub_q   <= 1'b0;
      baj_q   <= 1'b0;
      larga_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_ETAPAS-2:0], entrada_i ^ INVERTIR};
      cnt_q   <= cnt_d;
      cntl_q  <= cntl_d;
      est_q   <= est_d;
      sub_q   <= sub_d;
      baj_q   <= baj_d;
      larga_q <= larga_d;
    end
  end

  assign estable_o = est_q;
  assign subida_o  = sub_q;
  assign bajada_o  = baj_q;
  assign larga_o   = larga_q;
endmodule

module antirebote_multicanal #(
  parameter int                   N_CANALES       = 4,
  parameter int                   SYNC_ETAPAS     = 2,
  parameter int                   DEBOUNCE_CICLOS = 270000,
  parameter int                   LARGA_CICLOS    = 27000000,
  parameter logic [N_CANALES-1:0] INVERTIR        = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 habilitar,
  input  logic [N_CANALES-1:0] entradas_asinc,
  output logic [N_CANALES-1:0] salidas_estables,
  output logic [N_CANALES-1:0] pulso_subida,
  output logic [N_CANALES-1:0] pulso_bajada,
  output logic [N_CANALES-1:0] pulsacion_larga,
  output logic                 algun_evento
);
  for (genvar g = 0; g < N_CANALES; g++) begin : g_canal
    antirebote_canal #(
      .SYNC_ETAPAS    (SYNC_ETAPAS),
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
      .LARGA_CICLOS   (LARGA_CICLOS),
      .INVERTIR       (INVERTIR[g])
    ) u_canal (
      .clk        (clk),
      .rst        (rst),
      .habilitar_i(habilitar),
      .entrada_i  (entradas_asinc[g]),
      .estable_o  (salidas_estables[g]),
      .subida_o   (pulso_subida[g]),
      .bajada_o   (pulso_bajada[g]),
      .larga_o    (pulsacion_larga[g])
    );
  end

  // pulses are already registered, so this OR is glitch-free and cycle-aligned with them
  assign algun_evento = |(pulso_subida | pulso_bajada);
endmodule

// File: tb/tb_antirebote_multicanal.sv
// Bench for antirebote_multicanal: timestamp-based behavioural model checked every cycle,
// directed scenarios with literal latencies, then randomized pin/enable/reset traffic.

module tb_antirebote_multicanal;
  localparam int N = 4, SYNC = 2, D = 8, L = 32;
  localparam logic [N-1:0] INV = 4'b1000;

  logic         clk = 1'b0, rst = 1'b1, habilitar = 1'b0;
  logic [N-1:0] pins = INV;
  logic [N-1:0] sal, sub, baj, larga;
  logic         evt;
  int           checks = 0, errors = 0;

  antirebote_multicanal #(
    .N_CANALES(N), .SYNC_ETAPAS(SYNC), .DEBOUNCE_CICLOS(D), .LARGA_CICLOS(L), .INVERTIR(INV)
  ) dut (
    .clk(clk), .rst(rst), .habilitar(habilitar), .entradas_asinc(pins),
    .salidas_estables(sal), .pulso_subida(sub), .pulso_bajada(baj),
    .pulsacion_larga(larga), .algun_evento(evt)
  );

  always begin
    #19 clk = 1'b1;
    #18 clk = 1'b0;
  end

  task automatic chk(input string nm, input logic [N-1:0] a, input logic [N-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // model: sinc is the pin value from SYNC edges ago; a change is accepted on the D-th
  // consecutive enabled edge of disagreement; long pulse L edges after the hold count restarts
  logic [N-1:0] m_out, m_sub, m_baj, m_larga;
  int           since [N];
  int           held  [N];
  int           n = 0;
  logic [N-1:0] shist [$];

  task automatic model_clear();
    m_out = '0; m_sub = '0; m_baj = '0; m_larga = '0;
    shist.delete();
    for (int i = 0; i < SYNC; i++) shist.push_back('0);
    for (int i = 0; i < N; i++) begin
      since[i] = -1;
      held[i]  = n;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] sv, pre;
    n++;
    sv = shist.pop_front();
    shist.push_back(pins ^ INV);
    pre = m_out;
    m_sub = '0; m_baj = '0; m_larga = '0;
    for (int i = 0; i < N; i++) begin
      if (!habilitar) begin
        since[i] = -1;
        held[i]  = n;
      end else begin
        if (pre[i] && (n - held[i] == L)) m_larga[i] = 1'b1;
        if (!pre[i]) held[i] = n;
        if (sv[i] == pre[i]) since[i] = -1;
        else begin
          if (since[i] < 0) since[i] = n;
          if (n - since[i] + 1 == D) begin
            m_out[i] = sv[i];
            m_sub[i] = sv[i];
            m_baj[i] = !sv[i];
            since[i] = -1;
          end
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_clear();
      else model_edge();
    end
  end

  int nlong [N];
  int nevt = 0;
  initial begin
    for (int i = 0; i < N; i++) nlong[i] = 0;
    forever begin
      @(negedge clk);
      chk("salidas_estables", sal, m_out);
      chk("pulso_subida", sub, m_sub);
      chk("pulso_bajada", baj, m_baj);
      chk("pulsacion_larga", larga, m_larga);
      chk("algun_evento", {3'b0, evt}, {3'b0, |(m_sub | m_baj)});
      for (int i = 0; i < N; i++) if (larga[i]) nlong[i]++;
      if (evt) nevt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #5;
    end
  endtask

  task automatic wait_sal(input int ch, input logic v, input int maxc, output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (sal[ch] !== v && k < maxc);
  endtask

  task automatic wait_long(input int ch, input int maxc, output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (larga[ch] !== 1'b1 && k < maxc);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " salidas"}, sal, '0);
    chk({nm, " subida"}, sub, '0);
    chk({nm, " bajada"}, baj, '0);
    chk({nm, " larga"}, larga, '0);
    chk({nm, " evento"}, {3'b0, evt}, '0);
  endtask

  initial begin
    int k, base, base_l;
    int rate [N];

    // reset with random inputs
    #3;
    pins = 4'($urandom);
    habilitar = 1'($urandom);
    #1;
    chk_all_zero("reset");
    step(3);
    chk_all_zero("reset held");
    pins = INV;
    habilitar = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);

    // bounce on ch0, last edge to 1
    pins[0] = 1'b1; step(1);
    pins[0] = 1'b0; step(3);
    pins[0] = 1'b1; step(2);
    pins[0] = 1'b0; step(5);
    pins[0] = 1'b1;
    wait_sal(0, 1'b1, 30, k);
    chk_int("ch0 bounce latency", k, 10);
    chk("ch0 pulso_subida", sub, 4'b0001);
    chk("ch0 evento", {3'b0, evt}, 4'b0001);
    @(posedge clk); #1;
    chk("ch0 pulso_subida 1 cycle", sub, 4'b0000);
    chk("ch0 evento 1 cycle", {3'b0, evt}, 4'b0000);

    // glitch rejection on ch1
    step(1);
    pins[1] = 1'b1; step(7);
    pins[1] = 1'b0; step(15);
    chk("ch1 7-cycle glitch", {3'b0, sal[1]}, 4'b0000);
    pins[1] = 1'b1; step(8);
    pins[1] = 1'b0;
    wait_sal(1, 1'b1, 20, k);
    chk_int("ch1 8-cycle accepted", k, 2);
    step(20);

    // long press on ch2
    base = nlong[2];
    pins[2] = 1'b1;
    wait_sal(2, 1'b1, 30, k);
    chk_int("ch2 rise latency", k, 10);
    wait_long(2, 40, k);
    chk_int("ch2 long delay", k, 32);
    repeat (8) @(posedge clk);
    #4;
    pins[2] = 1'b0;
    wait_sal(2, 1'b0, 30, k);
    chk_int("ch2 fall latency", k, 10);
    chk("ch2 pulso_bajada", baj, 4'b0100);
    chk_int("ch2 one long pulse", nlong[2] - base, 1);
    step(5);
    base = nlong[2];
    pins[2] = 1'b1; step(20);
    pins[2] = 1'b0; step(40);
    chk_int("ch2 short press no long", nlong[2] - base, 0);

    // inverted ch3
    step(20);
    chk("ch3 idle inverted", {3'b0, sal[3]}, 4'b0000);
    pins[3] = 1'b0;
    wait_sal(3, 1'b1, 30, k);
    chk_int("ch3 inverted rise latency", k, 10);
    step(1);
    pins[3] = 1'b1;
    step(20);

    // freeze while disabled, then re-enable
    habilitar = 1'b0;
    pins[0] = 1'b0;
    step(20);
    chk("ch0 frozen", {3'b0, sal[0]}, 4'b0001);
    habilitar = 1'b1;
    wait_sal(0, 1'b0, 30, k);
    chk_int("ch0 re-enable latency", k, 8);
    chk("ch0 pulso_bajada after enable", baj, 4'b0001);
    step(1);

    // reset mid-press
    pins[2] = 1'b1;
    wait_sal(2, 1'b1, 30, k);
    step(5);
    base = nevt;
    base_l = nlong[2];
    rst = 1'b1;
    #1;
    chk_all_zero("reset mid-press");
    pins[2] = 1'b0;
    step(3);
    rst = 1'b0;
    step(40);
    chk_int("no events after reset", nevt - base, 0);
    chk_int("no long after reset", nlong[2] - base_l, 0);

    // randomized traffic
    for (int blk = 0; blk < 10; blk++) begin
      for (int i = 0; i < N; i++)
        case ($urandom_range(2))
          0:       rate[i] = 2;
          1:       rate[i] = 10;
          default: rate[i] = 60;
        endcase
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(rate[i] - 1) == 0) pins[i] = ~pins[i];
        if (habilitar) begin
          if ($urandom_range(149) == 0) habilitar = 1'b0;
        end else if ($urandom_range(9) == 0) habilitar = 1'b1;
        rst = ($urandom_range(399) == 0);
        step(1);
      end
    end
    rst = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
